// File: rtl/uart_tx_fifo.sv
// Byte FIFO and drain sequencer feeding a UART transmitter over its
// tx_ena / tx_data / tx_busy handshake.
// Optional feature macro: UART_TX_FIFO_IRQ_EN enables the registered irq_tx_low flag.
module uart_tx_fifo #(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned LOW_WATER = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  output logic               full,
  output logic               empty,
  output logic [ADDR_W:0]    level,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic               idle,
  output logic               tx_ena,
  output logic [D_WIDTH-1:0] tx_data,
  input  logic               tx_busy,
  output logic               irq_tx_low
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [D_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q;
  logic                push, pop;
  logic                tx_ena_d;
  logic [D_WIDTH-1:0]  tx_data_d;

  // Flags come from the level counter only; full is judged before any same-cycle pop
  assign full  = (level_q == (ADDR_W + 1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign push  = wr_en && !full;
  assign idle  = empty && (state_q == S_IDLE) && !tx_busy;

  // Next-state and handshake decode; a byte is offered only from S_IDLE with the UART free
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_ena_d  = 1'b0;
    tx_data_d = tx_data;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          tx_ena_d  = 1'b1;
          tx_data_d = mem[rd_ptr_q];
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) state_d = S_DONE;
      end
      S_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage array; contents deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // FSM, pointers, level counter, sticky overflow and registered UART outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
      tx_ena   <= 1'b0;
      tx_data  <= '0;
    end else begin
      state_q <= state_d;
      tx_ena  <= tx_ena_d;
      tx_data <= tx_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // A new overflow wins over a simultaneous clear
      if (wr_en && full)  overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_q;

  // Low-water flag, one cycle behind the level counter
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= (level_q <= (ADDR_W + 1)'(LOW_WATER));
  end

  assign irq_tx_low = irq_q;
`else
  logic unused_low_water;
  assign unused_low_water = (level_q <= (ADDR_W + 1)'(LOW_WATER));
  assign irq_tx_low       = 1'b0;
`endif

endmodule
